// File: rtl/run_sequencer_if.sv
// Host/CPU-facing signal bundle for run_sequencer.
// master: the sequencer side; slave: the host/CPU environment side.
interface run_sequencer_if;
  logic        go;
  logic        busy;
  logic        cpu_start;
  logic        cpu_done;
  logic        run_done;
  logic [15:0] cycles;
  logic        timed_out;
  logic [7:0]  run_count;

  modport master (
    input  go,
    input  cpu_done,
    output busy,
    output cpu_start,
    output run_done,
    output cycles,
    output timed_out,
    output run_count
  );

  modport slave (
    output go,
    output cpu_done,
    input  busy,
    input  cpu_start,
    input  run_done,
    input  cycles,
    input  timed_out,
    input  run_count
  );
endinterface

// File: rtl/run_sequencer.sv
// Launches one CPU run per go: parks the CPU in reset-like start, releases it, times the run.
// Optional watchdog on the RUN phase is enabled by defining RUN_WATCHDOG_EN.
module run_sequencer #(
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst_n,
  run_sequencer_if.master  bus
);

  if (START_CYCLES < 1 || START_CYCLES > 255) begin : g_bad_start
    $error("START_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StHold, StRun, StFin} state_e;

  localparam logic [7:0]  HoldLast = 8'(START_CYCLES - 1);
  localparam logic [15:0] CntMax   = 16'hFFFF;

  state_e      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [15:0] cycles_q, cycles_d;
  logic [7:0]  run_count_q, run_count_d;
  logic        done_ok;

  // run_cnt_q is 1 only in the first RUN cycle, where a stale done is blanked.
  assign done_ok = bus.cpu_done && (run_cnt_q != 16'd1);

`ifdef RUN_WATCHDOG_EN
  localparam logic [15:0] Timeout = 16'(TIMEOUT_CYCLES);
  logic timed_out_q, timed_out_d;
`endif

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    run_cnt_d   = run_cnt_q;
    cycles_d    = cycles_q;
    run_count_d = run_count_q;
`ifdef RUN_WATCHDOG_EN
    timed_out_d = timed_out_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d   = StRun;
          run_cnt_d = 16'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (done_ok) begin
          state_d     = StFin;
          cycles_d    = run_cnt_q;
          run_count_d = run_count_q + 8'd1;
`ifdef RUN_WATCHDOG_EN
          timed_out_d = 1'b0;
        end else if (run_cnt_q == Timeout) begin
          state_d     = StFin;
          cycles_d    = Timeout;
          run_count_d = run_count_q + 8'd1;
          timed_out_d = 1'b1;
`endif
        end else if (run_cnt_q != CntMax) begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      run_cnt_q   <= '0;
      cycles_q    <= '0;
      run_count_q <= '0;
`ifdef RUN_WATCHDOG_EN
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      run_cnt_q   <= run_cnt_d;
      cycles_q    <= cycles_d;
      run_count_q <= run_count_d;
`ifdef RUN_WATCHDOG_EN
      timed_out_q <= timed_out_d;
`endif
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.cpu_start = (state_q != StRun);
  assign bus.run_done  = (state_q == StFin);
  assign bus.cycles    = cycles_q;
  assign bus.run_count = run_count_q;
`ifdef RUN_WATCHDOG_EN
  assign bus.timed_out = timed_out_q;
`else
  assign bus.timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: timeline model checked every cycle plus directed literals.
// Define RUN_WATCHDOG_EN for both RTL and bench to exercise the watchdog cases.
module tb_run_sequencer;
  localparam int S  = 2;
  localparam int TO = 100;
`ifdef RUN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  run_sequencer_if bus ();

  run_sequencer #(
    .START_CYCLES   (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model: a run is a timeline measured in cycles since the launch edge.
  // Ages 1..S are start-hold cycles; age S+r is the r-th CPU run cycle.
  bit m_active = 1'b0;
  bit m_fin    = 1'b0;
  bit m_to     = 1'b0;
  int m_age    = 0;
  int m_cycles = 0;
  int m_count  = 0;

  always @(posedge clk) begin : model
    int r;
    r = m_age - S;
    if (!rst_n) begin
      m_active <= 1'b0;
      m_fin    <= 1'b0;
      m_to     <= 1'b0;
      m_age    <= 0;
      m_cycles <= 0;
      m_count  <= 0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (m_active) begin
      if (r >= 2 && bus.cpu_done) begin
        m_active <= 1'b0;
        m_fin    <= 1'b1;
        m_cycles <= (r > 65535) ? 65535 : r;
        m_to     <= 1'b0;
        m_count  <= (m_count + 1) % 256;
      end else if (WD && r == TO) begin
        m_active <= 1'b0;
        m_fin    <= 1'b1;
        m_cycles <= TO;
        m_to     <= 1'b1;
        m_count  <= (m_count + 1) % 256;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (bus.go) begin
      m_active <= 1'b1;
      m_age    <= 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [31:0] got;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        got = {4'b0, bus.busy, bus.cpu_start, bus.run_done, bus.timed_out,
               bus.run_count, bus.cycles};
        exp = {4'b0, (m_active || m_fin), !(m_active && m_age > S), m_fin, m_to,
               m_count[7:0], m_cycles[15:0]};
        check("cycle{busy,start,done,to,count,cycles}", got, exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse go for one cycle; returns at the first start-hold cycle.
  task automatic launch();
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!bus.run_done && n < budget) begin
      step(1);
      n++;
    end
    if (!bus.run_done) check("wait_run_done", {31'b0, bus.run_done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int last;
    bus.go       = 1'b0;
    bus.cpu_done = 1'b0;
    rst_n        = 1'b0;
    fork
      compare_loop();
    join_none
    step(2);
    cmp_en = 1'b1;

    check("rst_busy", bus.busy, 0);
    check("rst_cpu_start", bus.cpu_start, 1);
    check("rst_run_done", bus.run_done, 0);
    check("rst_cycles", bus.cycles, 0);
    check("rst_timed_out", bus.timed_out, 0);
    check("rst_run_count", bus.run_count, 0);
    rst_n = 1'b1;
    step(1);

    // Basic run: done raised in the 5th run cycle
    launch();
    check("hold1_start", bus.cpu_start, 1);
    check("hold1_busy", bus.busy, 1);
    step(1);
    check("hold2_start", bus.cpu_start, 1);
    step(1);
    check("run1_start", bus.cpu_start, 0);
    step(4);
    bus.cpu_done = 1'b1;
    step(1);
    bus.cpu_done = 1'b0;
    check("basic_run_done", bus.run_done, 1);
    check("basic_cycles", bus.cycles, 5);
    check("basic_run_count", bus.run_count, 1);
    check("basic_fin_start", bus.cpu_start, 1);
    step(1);
    check("basic_idle_done", bus.run_done, 0);
    check("basic_idle_busy", bus.busy, 0);

    // Stale done: held high before go, first run cycle blanked
    bus.cpu_done = 1'b1;
    step(1);
    launch();
    wait_done(20, n);
    check("stale_latency", n, 4);
    check("stale_cycles", bus.cycles, 2);
    bus.cpu_done = 1'b0;
    step(1);

    // go during RUN and during FIN must not queue a run
    launch();
    step(3);
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
    bus.cpu_done = 1'b1;
    step(1);
    check("ignore_fin_done", bus.run_done, 1);
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
    bus.cpu_done = 1'b0;
    step(8);
    check("ignore_busy", bus.busy, 0);
    check("ignore_run_count", bus.run_count, 3);
    check("ignore_cycles", bus.cycles, 3);

`ifdef RUN_WATCHDOG_EN
    // Watchdog expiry, then done exactly at the limit, then a short run
    launch();
    wait_done(200, n);
    check("wd_latency", n, 102);
    check("wd_cycles", bus.cycles, 100);
    check("wd_timed_out", bus.timed_out, 1);
    step(1);
    launch();
    step(101);
    bus.cpu_done = 1'b1;
    step(1);
    bus.cpu_done = 1'b0;
    check("wd_tie_done", bus.run_done, 1);
    check("wd_tie_timed_out", bus.timed_out, 0);
    check("wd_tie_cycles", bus.cycles, 100);
    step(1);
    launch();
    step(3);
    bus.cpu_done = 1'b1;
    step(1);
    bus.cpu_done = 1'b0;
    check("wd_normal_timed_out", bus.timed_out, 0);
    check("wd_normal_cycles", bus.cycles, 2);
    step(1);
`else
    // No watchdog: a run well past TIMEOUT_CYCLES keeps waiting for done
    launch();
    step(150);
    check("nowd_still_busy", bus.busy, 1);
    check("nowd_still_running", bus.cpu_start, 0);
    bus.cpu_done = 1'b1;
    step(1);
    bus.cpu_done = 1'b0;
    check("nowd_cycles", bus.cycles, 149);
    check("nowd_timed_out", bus.timed_out, 0);
    step(1);
`endif

    // Reset in the 3rd run cycle, with go held high through reset
    launch();
    step(4);
    rst_n  = 1'b0;
    bus.go = 1'b1;
    step(1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cpu_start", bus.cpu_start, 1);
    check("midrst_run_done", bus.run_done, 0);
    check("midrst_cycles", bus.cycles, 0);
    check("midrst_timed_out", bus.timed_out, 0);
    check("midrst_run_count", bus.run_count, 0);
    rst_n  = 1'b1;
    bus.go = 1'b0;
    step(3);
    check("midrst_stays_idle", bus.busy, 0);

    // 256 back-to-back runs wrap run_count to 0
    bus.go       = 1'b1;
    bus.cpu_done = 1'b1;
    pulses = 0;
    last   = 0;
    for (int i = 1; i <= 256 * 6 + 50; i++) begin
      step(1);
      if (bus.run_done) begin
        pulses++;
        if (pulses == 2) check("b2b_period", i - last, S + 4);
        if (pulses == 255) check("wrap_255", bus.run_count, 255);
        last = i;
        if (pulses == 256) begin
          check("wrap_0", bus.run_count, 0);
          bus.go = 1'b0;
          break;
        end
      end
    end
    bus.go       = 1'b0;
    bus.cpu_done = 1'b0;
    check("wrap_pulses", pulses, 256);
    step(3);
    check("wrap_idle", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
